// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Fetch/data request, completion and memory handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        err;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    output if_done, if_rdata, d_done, d_rdata, err, stall_if, stall_mem,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    input  if_done, if_rdata, d_done, d_rdata, err, stall_if, stall_mem,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Fetch/data arbiter for a single-ported memory, one access in flight.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  localparam int c_SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int c_TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
  localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic            r_id_d;
  logic            r_wr;
  logic [15:0]     r_addr;
  logic [15:0]     r_wdata;
  logic [15:0]     r_rdata;
  logic            r_err;
  logic [c_SW-1:0] r_starve;
  logic [c_TW-1:0] r_tmo;

  logic            w_grant_d;
  logic            w_grant_i;
  logic [15:0]     w_addr;
  logic            w_tmo_hit;
  logic            w_resp;
  logic            w_if_done;
  logic            w_d_done;

  // Data wins ties unless fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    w_grant_d = bus.d_req & (~bus.if_req | (r_starve != c_STARVE_MAX));
    w_grant_i = bus.if_req & ~w_grant_d;
    w_addr    = w_grant_d ? bus.d_addr : bus.if_addr;
    w_tmo_hit = (r_tmo == c_TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_id_d   <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_rdata  <= 16'h0000;
      r_err    <= 1'b0;
      r_starve <= '0;
      r_tmo    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_id_d  <= w_grant_d;
            r_wr    <= w_grant_d & bus.d_wr;
            r_addr  <= w_addr;
            r_wdata <= w_grant_d ? bus.d_wdata : 16'h0000;
            if (w_grant_d && bus.if_req) begin
              if (r_starve != c_STARVE_MAX) r_starve <= r_starve + 1'b1;
            end else begin
              r_starve <= '0;
            end
            // Misaligned accesses never reach the memory.
            if (w_addr[0]) begin
              r_state <= c_RESP;
              r_err   <= 1'b1;
              r_rdata <= 16'h0000;
            end else begin
              r_state <= c_ISSUE;
            end
          end
        end
        c_ISSUE: begin
          r_tmo   <= '0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (bus.mem_done) begin
            r_rdata <= r_wr ? 16'h0000 : bus.mem_rdata;
            r_err   <= 1'b0;
            r_state <= c_RESP;
          end else if (w_tmo_hit) begin
            r_rdata <= 16'h0000;
            r_err   <= 1'b1;
            r_state <= c_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign w_resp    = (r_state == c_RESP);
  assign w_if_done = w_resp & ~r_id_d;
  assign w_d_done  = w_resp & r_id_d;

  assign bus.if_done   = w_if_done;
  assign bus.d_done    = w_d_done;
  assign bus.if_rdata  = w_if_done ? r_rdata : 16'h0000;
  assign bus.d_rdata   = w_d_done ? r_rdata : 16'h0000;
  assign bus.err       = w_resp & r_err;
  assign bus.stall_if  = bus.if_req & ~w_if_done;
  assign bus.stall_mem = bus.d_req & ~w_d_done;
  assign bus.mem_en    = (r_state == c_ISSUE);
  assign bus.mem_wr    = r_wr;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch stage and the memory stage of the 16-bit pipelined core.
- Arbitrates requests and holds one outstanding access at a time. Drives the memory handshake, returns read data with a done pulse, and generates stall signals for the pipeline control.
- Flags misaligned accesses and memory timeouts as errors.

Parameters:
- STARVE_LIMIT, 2, number of consecutive data grants allowed while a fetch request is pending; the next grant goes to fetch.
- TIMEOUT, 64, number of WAIT cycles without mem_done before the access is aborted with an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held stable until if_done
- if_addr  in  16  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_rdata  out  16  fetch data, valid when if_done
- d_req  in  1  data request; held stable until d_done
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_done  out  1  one-cycle data completion pulse
- d_rdata  out  16  load data, valid when d_done (0 for stores)
- err  out  1  asserted with a done pulse when the access failed
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  d_req & ~d_done
- mem_en  out  1  one-cycle memory access strobe
- mem_wr  out  1  write enable, valid with mem_en
- mem_addr  out  16  registered address, stable from ISSUE through WAIT
- mem_wdata  out  16  registered write data
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, all outputs 0, starvation counter 0, timeout counter 0.
- Reset mid-access returns the block to IDLE with no done pulse. A later stray mem_done is ignored.
- Flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both pending: grant data, unless the starvation counter equals STARVE_LIMIT, in which case grant fetch.
  - On grant, latch the requester id, wr, addr and wdata. Fetch grants are always reads.
  - No request: stay in IDLE.
- Starvation counter:
  - Increments on each data grant made while if_req = 1.
  - Clears on any fetch grant, or on a data grant made while if_req = 0.
  - Saturates at STARVE_LIMIT.
- Misaligned grant (addr[0] = 1): go directly to RESP with err = 1. No mem_en is issued.
- ISSUE: mem_en = 1 for exactly one cycle with mem_wr, mem_addr and mem_wdata from the latched values. Next state WAIT.
- WAIT:
  - mem_addr, mem_wr and mem_wdata stay held.
  - The timeout counter starts at 0 and increments each cycle.
  - On mem_done: capture mem_rdata (store 0 for writes) and go to RESP with err = 0.
  - Counter reaching TIMEOUT without mem_done: go to RESP with err = 1, rdata = 0.
  - mem_done in the same cycle the counter reaches TIMEOUT: mem_done wins.
- RESP:
  - The done pulse of the granted requester is 1 for one cycle, with rdata and err driven. err is 0 outside RESP.
  - The completing requester's req is ignored this cycle. The next state is always IDLE.
  - The requester drops req or presents a new request by the following cycle.
- Latency: a request granted in IDLE at cycle N with mem_done arriving k cycles after mem_en (k >= 1) gives:
  - mem_en at N+1
  - done at N+2+k
  - The earliest re-grant is at N+3+k.
- Misaligned access latency: done at N+1.
- Memory ports: mem_en is never asserted outside ISSUE. mem_done outside WAIT is ignored.
- Stalls: stall_if and stall_mem are combinational from req and done. There are no other side effects.

Test Plan:
- Single load: d_req = 1, d_wr = 0, d_addr = 0x0010, memory returns 0xBEEF with mem_done 3 cycles after mem_en -> mem_en at N+1 with mem_addr = 0x0010; d_done and d_rdata = 0xBEEF at N+5; err = 0; stall_mem = 1 from N through N+4.
- Contention and starvation (STARVE_LIMIT = 2): if_req and d_req held continuously with new data requests -> grant order D, D, I, D, D, I; if_done occurs after exactly two d_done pulses.
- Store: d_wr = 1, d_addr = 0x0100, d_wdata = 0x1234 -> mem_wr = 1 and mem_wdata = 0x1234 with mem_en; d_done with d_rdata = 0x0000.
- Misaligned fetch: if_addr = 0x0003 -> no mem_en; if_done and err = 1 in the cycle after the request.
- Timeout (TIMEOUT = 64): mem_done never arrives -> done with err = 1 and rdata = 0 on the 64th WAIT cycle. Separately, mem_done arriving on that same cycle -> err = 0 with valid data.
- Reset during WAIT: rst pulsed one cycle, then mem_done arrives -> no done pulse, all outputs 0, state IDLE; a subsequent fetch of 0x0002 completes normally.
